// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, mode word and init FSM state type
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  // Burst write, CL=3, sequential, full-page burst
  localparam logic [11:0] MODE_WORD = 12'h037;

  // Idle / precharge-all bus values (A10=1 selects all banks)
  localparam logic [1:0]  BA_IDLE   = 2'b11;
  localparam logic [11:0] ADDR_IDLE = 12'hFFF;
  localparam logic [1:0]  BA_MODE   = 2'b00;

  typedef enum logic [2:0] {
    S_WAIT,
    S_PRE,
    S_TRP,
    S_AREF,
    S_TRC,
    S_MRS,
    S_TMRD,
    S_DONE
  } state_e;

endpackage

// File: rtl/sdram_init.sv
// rtl/sdram_init.sv - SDRAM power-up init sequencer (PRE, AREF x N, LOAD_MODE); macro SDRAM_INIT_FAST_SIM_EN shortens the power-up wait to 100 cycles
module sdram_init
  import sdram_pkg::*;
#(
  parameter int T_POWER  = 10000,
  parameter int T_RP     = 2,
  parameter int T_RC     = 7,
  parameter int T_MRD    = 3,
  parameter int AREF_NUM = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [3:0]  init_cmd,
  output logic [1:0]  init_ba,
  output logic [11:0] init_addr,
  output logic        init_done
);

`ifdef SDRAM_INIT_FAST_SIM_EN
  localparam int T_WAIT = 100;
`else
  localparam int T_WAIT = T_POWER;
`endif

  // One counter serves every wait state; size it for the longest wait so it never wraps.
  localparam int MAX_A = (T_POWER > T_WAIT) ? T_POWER : T_WAIT;
  localparam int MAX_B = (T_RC > T_RP) ? T_RC : T_RP;
  localparam int MAX_C = (MAX_B > T_MRD) ? MAX_B : T_MRD;
  localparam int MAX_T = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W  = $clog2(MAX_T + 1);
  localparam int AREF_W = $clog2(AREF_NUM + 1);

  // The counter reads n on the edge that ends cycle n of S_WAIT, so PRECHARGE
  // lands exactly on cycle T_WAIT. Gap states are entered one cycle after the
  // command, hence the "-2" terminal values (gaps must be at least 2 cycles).
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(T_WAIT);
  localparam logic [CNT_W-1:0]  TRP_LAST  = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0]  TRC_LAST  = CNT_W'(T_RC - 2);
  localparam logic [CNT_W-1:0]  TMRD_LAST = CNT_W'(T_MRD - 2);
  localparam logic [AREF_W-1:0] AREF_LAST = AREF_W'(AREF_NUM);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [AREF_W-1:0]   aref_q;
  logic [3:0]          cmd_q;
  logic [1:0]          ba_q;
  logic [11:0]         addr_q;
  logic                done_q;

  // Init sequencer: every output is registered and commands pulse for one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      aref_q  <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= BA_IDLE;
      addr_q  <= ADDR_IDLE;
      done_q  <= 1'b0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= BA_IDLE;
      addr_q <= ADDR_IDLE;
      case (state_q)
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q <= S_PRE;
            cnt_q   <= '0;
            cmd_q   <= CMD_PRECHARGE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PRE: begin
          state_q <= S_TRP;
          cnt_q   <= '0;
        end
        S_TRP: begin
          if (cnt_q == TRP_LAST) begin
            state_q <= S_AREF;
            cnt_q   <= '0;
            cmd_q   <= CMD_AUTO_REFRESH;
            aref_q  <= aref_q + AREF_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_AREF: begin
          state_q <= S_TRC;
          cnt_q   <= '0;
        end
        S_TRC: begin
          if (cnt_q == TRC_LAST) begin
            cnt_q <= '0;
            if (aref_q == AREF_LAST) begin
              state_q <= S_MRS;
              cmd_q   <= CMD_LOAD_MODE;
              ba_q    <= BA_MODE;
              addr_q  <= MODE_WORD;
            end else begin
              state_q <= S_AREF;
              cmd_q   <= CMD_AUTO_REFRESH;
              aref_q  <= aref_q + AREF_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_MRS: begin
          state_q <= S_TMRD;
          cnt_q   <= '0;
        end
        S_TMRD: begin
          if (cnt_q == TMRD_LAST) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_cmd  = cmd_q;
  assign init_ba   = ba_q;
  assign init_addr = addr_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_sdram_init.sv
// tb/tb_sdram_init.sv - self-checking bench for sdram_init (default and short-refresh instances)
`timescale 1ns/1ps
module tb_sdram_init;

  localparam int T_POWER = 10000;
`ifdef SDRAM_INIT_FAST_SIM_EN
  localparam int W_EFF = 100;
`else
  localparam int W_EFF = T_POWER;
`endif
  localparam int RP   = 2;
  localparam int MRD  = 3;
  localparam int RC1  = 7;
  localparam int N1   = 8;
  localparam int RC2  = 10;
  localparam int N2   = 2;
  localparam int END1 = W_EFF + RP + N1 * RC1 + MRD;
  localparam int RUN_LEN = END1 + 20;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  cmd1, cmd2;
  logic [1:0]  ba1, ba2;
  logic [11:0] addr1, addr2;
  logic        done1, done2;

  always #5 sys_clk = ~sys_clk;

  sdram_init dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .init_cmd (cmd1),
    .init_ba  (ba1),
    .init_addr(addr1),
    .init_done(done1)
  );

  sdram_init #(.T_POWER(T_POWER), .T_RP(RP), .T_RC(RC2), .T_MRD(MRD), .AREF_NUM(N2)) dut2 (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .init_cmd (cmd2),
    .init_ba  (ba2),
    .init_addr(addr2),
    .init_done(done2)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          off;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic        done;
  } vec_t;
  vec_t vtab[10];

  // Reference: command at cycle c derived directly from the issue-time formulas.
  function automatic logic [3:0] m_cmd(input int c, input int w, input int rp, input int rc, input int n);
    if (c == w) return PRE;
    for (int k = 1; k <= n; k++)
      if (c == w + rp + (k - 1) * rc) return AREF;
    if (c == w + rp + n * rc) return LMR;
    return NOP;
  endfunction

  function automatic logic m_done(input int c, input int w, input int rp, input int rc, input int n, input int mrd);
    return c >= w + rp + n * rc + mrd;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input int c, input logic [3:0] ecmd, input logic edone,
                             input logic [3:0] acmd, input logic [1:0] aba, input logic [11:0] aaddr,
                             input logic adone);
    chk({tag, "_cmd"},  c, 32'(acmd),  32'(ecmd));
    chk({tag, "_ba"},   c, 32'(aba),   (ecmd == LMR) ? 32'h0 : 32'h3);
    chk({tag, "_addr"}, c, 32'(aaddr), (ecmd == LMR) ? 32'h037 : 32'hFFF);
    chk({tag, "_done"}, c, 32'(adone), 32'(edone));
  endtask

  // Hold reset for ncyc edges from a negedge, checking idle outputs each cycle.
  task automatic do_reset(input int ncyc);
    sys_rst = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk_outputs("rst1", k, NOP, 1'b0, cmd1, ba1, addr1, done1);
      chk_outputs("rst2", k, NOP, 1'b0, cmd2, ba2, addr2, done2);
    end
    sys_rst = 1'b0;
  endtask

  task automatic run_seq(input int ncyc, input bit full, input bit time_chk);
    logic [3:0] seen[$];
    bit done_seen;
    done_seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk_outputs("dut1", c, m_cmd(c, W_EFF, RP, RC1, N1), m_done(c, W_EFF, RP, RC1, N1, MRD),
                  cmd1, ba1, addr1, done1);
      chk_outputs("dut2", c, m_cmd(c, W_EFF, RP, RC2, N2), m_done(c, W_EFF, RP, RC2, N2, MRD),
                  cmd2, ba2, addr2, done2);
      for (int i = 0; i < 10; i++) begin
        if (W_EFF + vtab[i].off == c) begin
          chk("vec_cmd",  c, 32'(cmd1),  32'(vtab[i].cmd));
          chk("vec_ba",   c, 32'(ba1),   32'(vtab[i].ba));
          chk("vec_addr", c, 32'(addr1), 32'(vtab[i].addr));
          chk("vec_done", c, 32'(done1), 32'(vtab[i].done));
        end
      end
      if (cmd1 !== NOP) seen.push_back(cmd1);
      if (time_chk && done1 === 1'b1 && !done_seen) begin
        done_seen = 1'b1;
        chk("done_before_160us", c, 32'($time < 160000), 32'd1);
      end
    end
    if (full) begin
      chk("cmd_count", ncyc, 32'(seen.size()), 32'd10);
      for (int i = 0; i < seen.size() && i < 10; i++)
        chk("cmd_order", i, 32'(seen[i]), (i == 0) ? 32'(PRE) : (i == 9) ? 32'(LMR) : 32'(AREF));
      if (time_chk) chk("done_seen", ncyc, 32'(done_seen), 32'd1);
    end
  endtask

  initial begin
    vtab[0] = '{0,  PRE,  2'b11, 12'hFFF, 1'b0};
    vtab[1] = '{1,  NOP,  2'b11, 12'hFFF, 1'b0};
    vtab[2] = '{2,  AREF, 2'b11, 12'hFFF, 1'b0};
    vtab[3] = '{9,  AREF, 2'b11, 12'hFFF, 1'b0};
    vtab[4] = '{51, AREF, 2'b11, 12'hFFF, 1'b0};
    vtab[5] = '{52, NOP,  2'b11, 12'hFFF, 1'b0};
    vtab[6] = '{58, LMR,  2'b00, 12'h037, 1'b0};
    vtab[7] = '{59, NOP,  2'b11, 12'hFFF, 1'b0};
    vtab[8] = '{60, NOP,  2'b11, 12'hFFF, 1'b0};
    vtab[9] = '{61, NOP,  2'b11, 12'hFFF, 1'b1};

    // Power-on reset held 3 cycles, then the full sequence.
    do_reset(3);
    run_seq(RUN_LEN, 1'b1, 1'b1);

    // Reset mid-refresh for 2 cycles, then a complete restart.
    do_reset(1);
    run_seq(W_EFF + 20, 1'b0, 1'b0);
    do_reset(2);
    run_seq(RUN_LEN, 1'b1, 1'b0);

    // Random abort points (including after done) with random reset lengths.
    for (int r = 0; r < 3; r++) begin
      do_reset(int'($urandom_range(3, 1)));
      run_seq(int'($urandom_range(END1 + 5, 1)), 1'b0, 1'b0);
    end
    do_reset(int'($urandom_range(3, 1)));
    run_seq(RUN_LEN, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
